// File: rtl/line_clear_if.sv
// Lock request / result / renderer-read bundle between the game controller and line_clear_unit.
interface line_clear_if #(
  parameter int COLS = 10
);
  logic              lock_valid;
  logic              lock_ready;
  logic [4:0]        lock_y;
  logic [4*COLS-1:0] lock_mask;
  logic              busy;
  logic              lines_valid;
  logic [3:0]        lines_cleared;
  logic              top_out;
  logic [4:0]        rd_row;
  logic [COLS-1:0]   rd_data;

  modport master (
    output lock_valid, lock_y, lock_mask, rd_row,
    input  lock_ready, busy, lines_valid, lines_cleared, top_out, rd_data
  );

  modport slave (
    input  lock_valid, lock_y, lock_mask, rd_row,
    output lock_ready, busy, lines_valid, lines_cleared, top_out, rd_data
  );
endinterface

// File: rtl/line_clear_unit.sv
// Playfield store: merges locked pieces, removes full rows bottom-up and compacts the board.
// Optional build macro LINE_CLEAR_STATS_EN adds a saturating total_lines counter output.
module line_clear_unit #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         restart_game,
  line_clear_if.slave  lc
`ifdef LINE_CLEAR_STATS_EN
  ,
  output logic [15:0]  total_lines
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_MERGE, S_SCAN, S_FILL, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        rd_q, rd_d, wr_q, wr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        lines_q;
  logic              lv_q, top_q;
  logic [4:0]        y_q;
  logic [4*COLS-1:0] mask_q;
  logic [COLS-1:0]   board_q [ROWS];
  logic [COLS-1:0]   board_d [ROWS];
  logic [5:0]        merge_row;
  logic [COLS-1:0]   row0_post;
  logic              accept;

  assign accept    = lc.lock_valid && (state_q == S_IDLE) && !restart_game;
  // Any clear zeroes row 0 during FILL, so only a clear-free pass can top out.
  assign row0_post = (cnt_q != 4'd0) ? '0 : board_q[0];

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    board_d   = board_q;
    merge_row = '0;
    case (state_q)
      S_IDLE: if (accept) state_d = S_MERGE;
      S_MERGE: begin
        for (int k = 0; k < 4; k++) begin
          merge_row = {1'b0, y_q} + 6'(k);
          if (merge_row < 6'(ROWS))
            board_d[merge_row[4:0]] = board_q[merge_row[4:0]] | mask_q[k*COLS +: COLS];
        end
        rd_d    = 5'(ROWS - 1);
        wr_d    = 5'(ROWS - 1);
        cnt_d   = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (&board_q[rd_q]) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          board_d[wr_q] = board_q[rd_q];
          wr_d          = wr_q - 5'd1;
        end
        rd_d = rd_q - 5'd1;
        if (rd_q == 5'd0) state_d = S_FILL;
      end
      S_FILL: begin
        for (int r = 0; r < ROWS; r++)
          if (r < int'(cnt_q)) board_d[r] = '0;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (restart_game) begin
      state_d = S_IDLE;
      for (int r = 0; r < ROWS; r++) board_d[r] = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      lv_q    <= 1'b0;
      top_q   <= 1'b0;
      for (int r = 0; r < ROWS; r++) board_q[r] <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      board_q <= board_d;
      lv_q    <= (state_q == S_FILL) && !restart_game;
      if (restart_game) begin
        lines_q <= '0;
        top_q   <= 1'b0;
      end else if (state_q == S_FILL) begin
        lines_q <= cnt_q;
        top_q   <= top_q | (row0_post != '0);
      end
    end
  end

  // Captured request payload; only meaningful once the handshake fires.
  always_ff @(posedge clock) begin
    if (accept) begin
      y_q    <= lc.lock_y;
      mask_q <= lc.lock_mask;
    end
  end

  assign lc.lock_ready    = (state_q == S_IDLE);
  assign lc.busy          = (state_q != S_IDLE);
  assign lc.lines_valid   = lv_q;
  assign lc.lines_cleared = lines_q;
  assign lc.top_out       = top_q;
  assign lc.rd_data       = (lc.rd_row < 5'(ROWS)) ? board_q[lc.rd_row] : '0;

`ifdef LINE_CLEAR_STATS_EN
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [15:0] total_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                total_q <= '0;
    else if (restart_game)    total_q <= '0;
    else if (state_q == S_DONE) total_q <= sat_add16(total_q, lines_q);
  end

  assign total_lines = total_q;
`endif

endmodule

// File: tb/tb_line_clear_unit.sv
// Bench for line_clear_unit: whole-board reference model, per-cycle compare, directed and random stimulus.
module tb_line_clear_unit;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int BUSY_CYC = ROWS + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic restart = 1'b0;
  always #5 clk = ~clk;

  line_clear_if #(.COLS(COLS)) bus();
`ifdef LINE_CLEAR_STATS_EN
  logic [15:0] total_lines;
`endif

  line_clear_unit #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clock       (clk),
    .reset       (rst),
    .restart_game(restart),
    .lc          (bus)
`ifdef LINE_CLEAR_STATS_EN
    ,
    .total_lines (total_lines)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [COLS-1:0] m_board   [ROWS] = '{default: '0};
  logic [COLS-1:0] res_board [ROWS] = '{default: '0};
  int              m_timer = 0;
  logic            m_lv = 1'b0;
  logic [3:0]      m_lines = '0;
  logic [3:0]      res_cnt = '0;
  logic            m_top = 1'b0;
  logic            res_top = 1'b0;
  int              m_total = 0;

  // Merge the piece, then keep the non-full rows in bottom-to-top order and stack them at the bottom.
  function automatic void compute(input int y, input logic [4*COLS-1:0] mask);
    logic [COLS-1:0] tmp [ROWS];
    logic [COLS-1:0] keep [$];
    tmp = m_board;
    for (int k = 0; k < 4; k++)
      if (y + k < ROWS) tmp[y+k] = tmp[y+k] | mask[k*COLS +: COLS];
    for (int r = ROWS - 1; r >= 0; r--)
      if (tmp[r] != {COLS{1'b1}}) keep.push_back(tmp[r]);
    res_cnt = 4'(ROWS - keep.size());
    for (int r = 0; r < ROWS; r++) res_board[r] = '0;
    for (int i = 0; i < keep.size(); i++) res_board[ROWS-1-i] = keep[i];
    res_top = (res_board[0] != '0);
  endfunction

  always @(posedge clk) begin
    if (rst || restart) begin
      for (int r = 0; r < ROWS; r++) m_board[r] = '0;
      m_timer = 0; m_lv = 1'b0; m_lines = '0; m_top = 1'b0; m_total = 0;
    end else begin
      m_lv = 1'b0;
      if (m_timer == 0) begin
        if (bus.lock_valid) begin
          compute(int'(bus.lock_y), bus.lock_mask);
          m_timer = BUSY_CYC;
        end
      end else begin
        m_timer--;
        if (m_timer == 1) begin
          m_lv = 1'b1;
          m_lines = res_cnt;
          if (res_top) m_top = 1'b1;
          m_board = res_board;
        end
        if (m_timer == 0) m_total = (m_total + int'(m_lines) > 65535) ? 65535 : m_total + int'(m_lines);
      end
    end
  end

  always @(negedge clk) begin
    logic [COLS-1:0] exp_rd;
    chk("lock_ready", bus.lock_ready, m_timer == 0);
    chk("busy", bus.busy, m_timer != 0);
    chk("lines_valid", bus.lines_valid, m_lv);
    chk("lines_cleared", bus.lines_cleared, m_lines);
    chk("top_out", bus.top_out, m_top);
    if (m_timer == 0) begin
      exp_rd = '0;
      if (bus.rd_row < 5'(ROWS)) exp_rd = m_board[bus.rd_row];
      chk("rd_data", bus.rd_data, exp_rd);
    end
`ifdef LINE_CLEAR_STATS_EN
    chk("total_lines", total_lines, m_total);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  function automatic logic [4*COLS-1:0] mk(input logic [COLS-1:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  task automatic do_lock(input logic [4:0] y, input logic [4*COLS-1:0] m, input bit hold, output int lat);
    int w;
    w = 0;
    while (!bus.lock_ready && w < 50) begin tick(); w++; end
    if (!bus.lock_ready) chk("ready_timeout", 1'b0, 1'b1);
    bus.lock_valid = 1'b1; bus.lock_y = y; bus.lock_mask = m;
    @(posedge clk); #1;
    bus.lock_valid = hold;
    if (hold) bus.lock_mask = '1;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 10) bus.lock_valid = 1'b0;
      if (bus.lines_valid) begin lat = c; break; end
    end
    #1;
    bus.lock_valid = 1'b0;
    if (lat == 0) chk("lines_valid_timeout", 1'b0, 1'b1);
    tick();
  endtask

  task automatic rd_chk(input string name, input int r, input logic [COLS-1:0] exp);
    bus.rd_row = 5'(r);
    #1;
    chk(name, bus.rd_data, exp);
  endtask

  task automatic do_restart();
    restart = 1'b1; tick(); restart = 1'b0; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    bus.lock_valid = 1'b0; bus.lock_y = '0; bus.lock_mask = '0; bus.rd_row = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset in the middle of an operation.
    bus.lock_valid = 1'b1; bus.lock_y = 5'd16; bus.lock_mask = mk('0, '0, '0, 10'h1FF);
    @(posedge clk); #1 bus.lock_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.lock_ready, 1'b1);
    chk("rst_lines_valid", bus.lines_valid, 1'b0);
    chk("rst_top_out", bus.top_out, 1'b0);
    #1;
    for (int r = 0; r < ROWS; r++) rd_chk("rst_row", r, '0);
    rst = 1'b0;
    tick();

    // Single clear.
    do_lock(5'd16, mk('0, '0, '0, 10'h1FF), 1'b0, lat);
    chk("single_setup_cleared", bus.lines_cleared, 4'd0);
    rd_chk("single_setup_row19", 19, 10'h1FF);
    do_lock(5'd16, mk('0, '0, '0, 10'h200), 1'b0, lat);
    chk("single_latency", lat, 23);
    chk("single_cleared", bus.lines_cleared, 4'd1);
    rd_chk("single_row19", 19, '0);

    // Tetris with compaction.
    do_lock(5'd16, mk(10'h3FE, 10'h3FE, 10'h3FE, 10'h3FE), 1'b0, lat);
    do_lock(5'd15, mk(10'h00F, '0, '0, '0), 1'b0, lat);
    do_lock(5'd16, mk(10'h001, 10'h001, 10'h001, 10'h001), 1'b0, lat);
    chk("tetris_cleared", bus.lines_cleared, 4'd4);
    rd_chk("tetris_row19", 19, 10'h00F);
    for (int r = 0; r < ROWS - 1; r++) rd_chk("tetris_upper_rows", r, '0);
`ifdef LINE_CLEAR_STATS_EN
    chk("stats_total_5", total_lines, 16'd5);
`endif

    // Non-contiguous clears.
    do_restart();
`ifdef LINE_CLEAR_STATS_EN
    chk("stats_total_after_restart", total_lines, 16'd0);
`endif
    do_lock(5'd17, mk(10'h3FE, 10'h001, 10'h3FE, '0), 1'b0, lat);
    do_lock(5'd17, mk(10'h001, '0, 10'h001, '0), 1'b0, lat);
    chk("noncontig_cleared", bus.lines_cleared, 4'd2);
    rd_chk("noncontig_row19", 19, 10'h001);
    rd_chk("noncontig_row18", 18, '0);
    rd_chk("noncontig_row17", 17, '0);

    // Top-out, bounds, and requests while busy.
    do_restart();
    do_lock(5'd0, mk(10'h001, '0, '0, '0), 1'b0, lat);
    chk("topout_cleared", bus.lines_cleared, 4'd0);
    chk("topout_set", bus.top_out, 1'b1);
    do_lock(5'd18, mk(10'h003, 10'h003, 10'h3FF, 10'h3FF), 1'b1, lat);
    chk("bounds_cleared", bus.lines_cleared, 4'd0);
    chk("topout_sticky", bus.top_out, 1'b1);
    chk("busy_ignored_idle", bus.busy, 1'b0);
    rd_chk("bounds_row18", 18, 10'h003);
    rd_chk("bounds_row19", 19, 10'h003);
    rd_chk("bounds_row0", 0, 10'h001);
    rd_chk("bounds_row1", 1, '0);
    rd_chk("rd_out_of_range", 25, '0);

    // Restart during SCAN.
    bus.lock_valid = 1'b1; bus.lock_y = 5'd16; bus.lock_mask = mk(10'h3FF, '0, '0, '0);
    @(posedge clk); #1 bus.lock_valid = 1'b0;
    repeat (8) tick();
    restart = 1'b1; tick(); restart = 1'b0;
    seen = 0;
    repeat (30) begin @(negedge clk); if (bus.lines_valid) seen++; end
    #1;
    chk("restart_no_strobe", seen, 0);
    chk("restart_top_out", bus.top_out, 1'b0);
    for (int r = 0; r < ROWS; r++) rd_chk("restart_board", r, '0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [COLS-1:0] rows [4];
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0: rows[k] = '0;
          1: rows[k] = '1;
          2: rows[k] = {COLS{1'b1}} ^ (COLS'(1) << $urandom_range(0, COLS - 1));
          default: rows[k] = COLS'($urandom);
        endcase
      end
      bus.lock_valid = ($urandom_range(0, 2) == 0);
      bus.lock_y     = 5'($urandom_range(0, 23));
      bus.lock_mask  = mk(rows[0], rows[1], rows[2], rows[3]);
      bus.rd_row     = 5'($urandom_range(0, 31));
      restart        = ($urandom_range(0, 149) == 0);
      rst            = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; restart = 1'b0; bus.lock_valid = 1'b0;
    repeat (30) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
